// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller.
//   sac_state_t : controller phase encoding
//   pipe_lat()  : array pipeline latency, rows + cols - 1
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } sac_state_t;

    function automatic int unsigned pipe_lat(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/sac_step_counter.sv
// Loadable, enable-gated up-counter with terminal-count flag.
//   clk, rst_n  : clock, async active-low reset
//   load        : load load_val (priority over en)
//   en          : increment by one
//   term        : terminal value; tc = (cnt == term)
//   cnt         : registered count
//   cnt_nxt     : value cnt takes after the next edge
module sac_step_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign tc      = (cnt_q == term);

endmodule

// File: rtl/systolic_array_controller.sv
// Job sequencer for a ROWS x COLS weight-stationary systolic array:
// clear -> shift weights (one row/cycle) -> stream K vectors -> drain.
// Optional macro SAC_WEIGHT_REUSE_EN adds KEEP_WEIGHTS: once a job has
// completed since reset, a START with KEEP_WEIGHTS=1 skips clear/load.
//   CLK, ASYNC_RST      : clock, async active-low reset
//   START, NUM_VECTORS  : job request (IDLE only) and vector count K
//   STALL               : freezes LOAD_W/STREAM/DRAIN progress
//   BUSY, DONE          : job in progress, 1-cycle end pulse
//   PE_EN/LOAD/SYNC_RST : array controls
//   W_RD_*, IN_RD_*     : buffer read ports (1-cycle latency)
//   IN_VALID            : array input carries real data
//   OUT_WR_*            : result buffer write port
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned MAX_VEC = 256,
    parameter int unsigned ADDR_W  = 8,
    localparam int unsigned CNT_W  = $clog2(MAX_VEC + 1)
) (
    input  logic              CLK,
    input  logic              ASYNC_RST,
    input  logic              START,
    input  logic [CNT_W-1:0]  NUM_VECTORS,
    input  logic              STALL,
`ifdef SAC_WEIGHT_REUSE_EN
    input  logic              KEEP_WEIGHTS,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic              PE_EN,
    output logic              PE_LOAD,
    output logic              PE_SYNC_RST,
    output logic              W_RD_EN,
    output logic [ADDR_W-1:0] W_RD_ADDR,
    output logic              IN_RD_EN,
    output logic [ADDR_W-1:0] IN_RD_ADDR,
    output logic              IN_VALID,
    output logic              OUT_WR_EN,
    output logic [ADDR_W-1:0] OUT_WR_ADDR
);

    localparam int unsigned L  = pipe_lat(ROWS, COLS);
    localparam int unsigned SW = CNT_W + 1;

    sac_state_t        state_q, state_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  k_sat;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pe_en_q, pe_en_d;
    logic              pe_load_q, pe_load_d;
    logic              pe_srst_q, pe_srst_d;
    logic              w_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0] w_rd_addr_q, w_rd_addr_d;
    logic              in_rd_en_q, in_rd_en_d;
    logic              in_valid_q, in_valid_d;
    logic              out_wr_en_q, out_wr_en_d;

    logic              stall_act;
    logic              reuse_ok;
    logic              in_rd_start_c;
    logic              in_rd_fire;
    logic              out_wr_fire;

    logic [CNT_W-1:0]  step_q, step_nxt, step_term;
    logic              step_tc, step_ld, step_en;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic              rd_tc, wr_tc;
    logic              cnt_clr;
    logic              unused_ok;

    assign k_sat = (NUM_VECTORS > CNT_W'(MAX_VEC)) ? CNT_W'(MAX_VEC) : NUM_VECTORS;

    // STALL only freezes the phases that move data through the array.
    assign stall_act = STALL & (state_q inside {S_LOAD_W, S_STREAM, S_DRAIN});

`ifdef SAC_WEIGHT_REUSE_EN
    logic wv_q, wv_d;

    // Weights become valid once a full job has drained; reset clears them.
    assign wv_d     = wv_q | ((state_q == S_DRAIN) & (state_d == S_DONE));
    assign reuse_ok = KEEP_WEIGHTS & wv_q;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            wv_q <= 1'b0;
        end else begin
            wv_q <= wv_d;
        end
    end
`else
    assign reuse_ok = 1'b0;
`endif

    // A reuse job must fetch vector 0 in the START cycle itself.
    assign in_rd_start_c = (state_q == S_IDLE) & START & reuse_ok & (k_sat != '0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    k_d = k_sat;
                    if (k_sat == '0) begin
                        state_d = S_DONE;
                    end else if (reuse_ok) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR:  state_d = S_LOAD_W;
            S_LOAD_W: if (!stall_act && step_tc) state_d = S_STREAM;
            S_STREAM: if (!stall_act && step_tc) state_d = S_DRAIN;
            S_DRAIN:  if (!stall_act && step_tc) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Phase step counter: restarts at 0 on every phase change.
    always_comb begin
        step_term = '0;
        case (state_q)
            S_LOAD_W: step_term = CNT_W'(ROWS - 1);
            S_STREAM: step_term = k_q - CNT_W'(1);
            S_DRAIN:  step_term = CNT_W'(L - 1);
            default:  step_term = '0;
        endcase
    end

    assign step_ld = (state_d != state_q);
    assign step_en = ~stall_act & (state_q inside {S_LOAD_W, S_STREAM, S_DRAIN});

    sac_step_counter #(.W(CNT_W)) u_step_cnt (
        .clk      (CLK),
        .rst_n    (ASYNC_RST),
        .load     (step_ld),
        .load_val ('0),
        .en       (step_en),
        .term     (step_term),
        .cnt      (step_q),
        .cnt_nxt  (step_nxt),
        .tc       (step_tc)
    );

    // Read/write addresses advance on each issued access and rewind at job end.
    assign cnt_clr = (state_d == S_DONE);

    sac_step_counter #(.W(ADDR_W)) u_rd_cnt (
        .clk      (CLK),
        .rst_n    (ASYNC_RST),
        .load     (cnt_clr),
        .load_val ('0),
        .en       (in_rd_fire),
        .term     ('0),
        .cnt      (rd_addr_q),
        .cnt_nxt  (rd_addr_nxt),
        .tc       (rd_tc)
    );

    sac_step_counter #(.W(ADDR_W)) u_wr_cnt (
        .clk      (CLK),
        .rst_n    (ASYNC_RST),
        .load     (cnt_clr),
        .load_val ('0),
        .en       (out_wr_fire),
        .term     ('0),
        .cnt      (wr_addr_q),
        .cnt_nxt  (wr_addr_nxt),
        .tc       (wr_tc)
    );

    // Outputs for the upcoming cycle, decoded from next state and next step.
    always_comb begin
        busy_d      = state_d inside {S_CLEAR, S_LOAD_W, S_STREAM, S_DRAIN};
        done_d      = (state_d == S_DONE);
        pe_en_d     = state_d inside {S_LOAD_W, S_STREAM, S_DRAIN};
        pe_load_d   = (state_d == S_LOAD_W);
        pe_srst_d   = (state_d == S_CLEAR);
        in_valid_d  = (state_d == S_STREAM);
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = '0;
        in_rd_en_d  = 1'b0;
        out_wr_en_d = 1'b0;
        case (state_d)
            S_CLEAR: begin
                w_rd_en_d   = 1'b1;
                w_rd_addr_d = ADDR_W'(ROWS - 1);
            end
            S_LOAD_W: begin
                // Rows are fetched one step ahead; the last step prefetches vector 0.
                if (step_nxt < CNT_W'(ROWS - 1)) begin
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = ADDR_W'(ROWS - 2) - ADDR_W'(step_nxt);
                end else begin
                    in_rd_en_d = 1'b1;
                end
            end
            S_STREAM: begin
                in_rd_en_d  = (step_nxt < (k_d - CNT_W'(1)));
                out_wr_en_d = (step_nxt >= CNT_W'(L));
            end
            S_DRAIN: begin
                // Results emerge L steps after their vector entered the array.
                out_wr_en_d = ((SW'(step_nxt) + SW'(k_d)) >= SW'(L));
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_en_q     <= 1'b0;
            pe_load_q   <= 1'b0;
            pe_srst_q   <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            in_rd_en_q  <= 1'b0;
            in_valid_q  <= 1'b0;
            out_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_en_q     <= pe_en_d;
            pe_load_q   <= pe_load_d;
            pe_srst_q   <= pe_srst_d;
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            in_rd_en_q  <= in_rd_en_d;
            in_valid_q  <= in_valid_d;
            out_wr_en_q <= out_wr_en_d;
        end
    end

    // Stall masks the strobes in the same cycle; the registered values hold.
    assign in_rd_fire  = (in_rd_en_q & ~stall_act) | in_rd_start_c;
    assign out_wr_fire = out_wr_en_q & ~stall_act;

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign PE_EN       = pe_en_q & ~stall_act;
    assign PE_LOAD     = pe_load_q & ~stall_act;
    assign PE_SYNC_RST = pe_srst_q;
    assign W_RD_EN     = w_rd_en_q & ~stall_act;
    assign W_RD_ADDR   = w_rd_addr_q;
    assign IN_RD_EN    = in_rd_fire;
    assign IN_RD_ADDR  = rd_addr_q;
    assign IN_VALID    = in_valid_q;
    assign OUT_WR_EN   = out_wr_fire;
    assign OUT_WR_ADDR = wr_addr_q;

    assign unused_ok = ^{step_q, rd_addr_nxt, rd_tc, wr_addr_nxt, wr_tc};

endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed bench for systolic_array_controller (ROWS=COLS=4, L=7).
// Each job pushes its expected read/write/done events into queues; the
// per-cycle monitor pops and compares them as the DUT emits strobes.
module tb_systolic_array_controller;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int MAX_VEC = 256;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = $clog2(MAX_VEC + 1);
    localparam int L       = ROWS + COLS - 1;

    logic              CLK = 1'b0;
    logic              ASYNC_RST;
    logic              START;
    logic [CNT_W-1:0]  NUM_VECTORS;
    logic              STALL;
    logic              KEEP_WEIGHTS;
    logic              BUSY, DONE, PE_EN, PE_LOAD, PE_SYNC_RST;
    logic              W_RD_EN, IN_RD_EN, IN_VALID, OUT_WR_EN;
    logic [ADDR_W-1:0] W_RD_ADDR, IN_RD_ADDR, OUT_WR_ADDR;

    always #5 CLK = ~CLK;

    systolic_array_controller #(
        .ROWS(ROWS), .COLS(COLS), .MAX_VEC(MAX_VEC), .ADDR_W(ADDR_W)
    ) dut (
        .CLK         (CLK),
        .ASYNC_RST   (ASYNC_RST),
        .START       (START),
        .NUM_VECTORS (NUM_VECTORS),
        .STALL       (STALL),
`ifdef SAC_WEIGHT_REUSE_EN
        .KEEP_WEIGHTS(KEEP_WEIGHTS),
`endif
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PE_EN       (PE_EN),
        .PE_LOAD     (PE_LOAD),
        .PE_SYNC_RST (PE_SYNC_RST),
        .W_RD_EN     (W_RD_EN),
        .W_RD_ADDR   (W_RD_ADDR),
        .IN_RD_EN    (IN_RD_EN),
        .IN_RD_ADDR  (IN_RD_ADDR),
        .IN_VALID    (IN_VALID),
        .OUT_WR_EN   (OUT_WR_EN),
        .OUT_WR_ADDR (OUT_WR_ADDR)
    );

    typedef struct { int cyc; int addr; } ev_t;

    ev_t q_w[$];
    ev_t q_in[$];
    ev_t q_wr[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    bit  stall_m[0:511];
    bit  start_m[0:511];
    int  exp_end, exp_en, exp_load, exp_srst, exp_k, act_lo;
    bit  wv_model = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({BUSY, DONE, PE_EN, PE_LOAD, PE_SYNC_RST, W_RD_EN, W_RD_ADDR,
                    IN_RD_EN, IN_RD_ADDR, IN_VALID, OUT_WR_EN, OUT_WR_ADDR});
    endfunction

    task automatic clear_masks();
        for (int i = 0; i < 512; i++) begin
            stall_m[i] = 1'b0;
            start_m[i] = 1'b0;
        end
    endtask

    // Build the expected event timeline of one job (START in cycle 0).
    task automatic plan(input int k_in, input bit reuse);
        int c;
        q_w.delete(); q_in.delete(); q_wr.delete();
        exp_k    = (k_in > MAX_VEC) ? MAX_VEC : k_in;
        exp_en   = 0;
        exp_load = 0;
        exp_srst = 0;
        act_lo   = reuse ? 1 : 2;
        if (exp_k == 0) begin
            exp_end = 1;
            return;
        end
        c = 1;
        if (reuse) begin
            q_in.push_back('{0, 0});
        end else begin
            q_w.push_back('{1, ROWS - 1});
            exp_srst = 1;
            c = 2;
            for (int i = 0; i < ROWS; i++) begin
                while (stall_m[c]) c++;
                exp_load++;
                exp_en++;
                if (i < ROWS - 1) q_w.push_back('{c, ROWS - 2 - i});
                else              q_in.push_back('{c, 0});
                c++;
            end
        end
        // Stream steps t < K, then L drain steps; result t-L written at step t.
        for (int t = 0; t < exp_k + L; t++) begin
            while (stall_m[c]) c++;
            exp_en++;
            if (t < exp_k - 1) q_in.push_back('{c, t + 1});
            if (t >= L)        q_wr.push_back('{c, (t - L) % 256});
            c++;
        end
        exp_end = c;
    endtask

    task automatic take(input int which, input int c, input logic en, input logic [ADDR_W-1:0] addr,
                        input string tag);
        ev_t e;
        bit  have;
        have = 1'b0;
        case (which)
            0: if (q_w.size()  != 0) begin e = q_w.pop_front();  have = 1'b1; end
            1: if (q_in.size() != 0) begin e = q_in.pop_front(); have = 1'b1; end
            default: if (q_wr.size() != 0) begin e = q_wr.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            check({tag, "_extra"}, 64'(en), 64'(0));
        end else begin
            check({tag, "_cyc"},  64'(c),    64'(e.cyc));
            check({tag, "_addr"}, 64'(addr), 64'(e.addr));
        end
    endtask

    task automatic run_job(input int k_in, input bit keep, input int abort_cyc);
        int cnt_en, cnt_load, cnt_srst, cnt_valid;
        cnt_en = 0; cnt_load = 0; cnt_srst = 0; cnt_valid = 0;
        plan(k_in, keep && wv_model);
        @(negedge CLK);
        for (int c = 0; c <= exp_end + 2; c++) begin
            if (c > 0) @(negedge CLK);
            START        = (c == 0) || start_m[c];
            NUM_VECTORS  = (c == 0) ? CNT_W'(k_in) : CNT_W'($urandom);
            KEEP_WEIGHTS = keep;
            STALL        = stall_m[c];
            if (c == abort_cyc) begin
                ASYNC_RST = 1'b0;
                #1;
                check("abort_outs_zero", all_outs(), 64'(0));
                @(negedge CLK);
                check("abort_no_done", 64'(DONE), 64'(0));
                START = 1'b0;
                STALL = 1'b0;
                ASYNC_RST = 1'b1;
                q_w.delete(); q_in.delete(); q_wr.delete();
                wv_model = 1'b0;
                return;
            end
            #1;
            check("busy", 64'(BUSY), 64'((exp_k > 0) && (c >= 1) && (c < exp_end)));
            check("done", 64'(DONE), 64'(c == exp_end));
            if (W_RD_EN)   take(0, c, W_RD_EN,   W_RD_ADDR,   "w_rd");
            if (IN_RD_EN)  take(1, c, IN_RD_EN,  IN_RD_ADDR,  "in_rd");
            if (OUT_WR_EN) take(2, c, OUT_WR_EN, OUT_WR_ADDR, "out_wr");
            if (stall_m[c] && (c >= act_lo) && (c < exp_end))
                check("stall_gate", 64'({PE_EN, PE_LOAD, W_RD_EN, IN_RD_EN, OUT_WR_EN}), 64'(0));
            cnt_en    += int'(PE_EN);
            cnt_load  += int'(PE_LOAD);
            cnt_srst  += int'(PE_SYNC_RST);
            cnt_valid += int'(IN_VALID && !STALL);
        end
        START = 1'b0;
        STALL = 1'b0;
        check("pe_en_count",   64'(cnt_en),    64'(exp_en));
        check("pe_load_count", 64'(cnt_load),  64'(exp_load));
        check("sync_rst_count",64'(cnt_srst),  64'(exp_srst));
        check("in_valid_count",64'(cnt_valid), 64'(exp_k));
        check("w_rd_missing",  64'(q_w.size()),  64'(0));
        check("in_rd_missing", 64'(q_in.size()), 64'(0));
        check("out_wr_missing",64'(q_wr.size()), 64'(0));
        if (exp_k > 0) wv_model = 1'b1;
    endtask

    initial begin
        ASYNC_RST    = 1'b0;
        START        = 1'b0;
        STALL        = 1'b0;
        NUM_VECTORS  = '0;
        KEEP_WEIGHTS = 1'b0;
        clear_masks();
        repeat (2) @(negedge CLK);
        #1;
        check("reset_outs_zero", all_outs(), 64'(0));
        ASYNC_RST = 1'b1;

`ifdef SAC_WEIGHT_REUSE_EN
        // No job completed yet: KEEP_WEIGHTS must still load weights.
        run_job(2, 1'b1, -1);
`endif
        // Scenario 1: K=3, no stall.
        run_job(3, 1'b0, -1);
        // Scenario 2: stall in cycles 7-8.
        stall_m[7] = 1'b1; stall_m[8] = 1'b1;
        run_job(3, 1'b0, -1);
        clear_masks();
        // Stall in CLEAR is ignored; stalls in LOAD_W and DRAIN delay.
        stall_m[1] = 1'b1; stall_m[3] = 1'b1; stall_m[12] = 1'b1;
        run_job(2, 1'b0, -1);
        clear_masks();
        // Scenario 3: K=0.
        run_job(0, 1'b0, -1);
        // Scenario 4: reset at cycle 10, then a full job.
        run_job(3, 1'b0, 10);
        run_job(3, 1'b0, -1);
        // Scenario 5: START while busy.
        start_m[7] = 1'b1;
        run_job(3, 1'b0, -1);
        clear_masks();
        // K > L: writes start during STREAM.
        run_job(9, 1'b0, -1);
        // K > MAX_VEC saturates.
        run_job(300, 1'b0, -1);
`ifdef SAC_WEIGHT_REUSE_EN
        // Scenario 6: weight reuse, K=2.
        run_job(2, 1'b1, -1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
